// File: rtl/miriscv_lsu_if.sv
`default_nettype none
// ============================================================================
// Module   : miriscv_lsu_if
// Purpose  : Data-port bus between the miriscv LSU (initiator) and the
//            unified RAM (target). The RAM returns read data one cycle after
//            the edge that samples data_req_o.
// Signals  : data_req_o    request strobe
//            data_we_o     write enable
//            data_be_o     byte enables, one per lane
//            data_addr_o   word-aligned byte address
//            data_wdata_o  lane-replicated write data
//            data_rdata_i  registered read data
// Modports : master (LSU side), slave (RAM side)
// Revision : 1.0 - initial release
// ============================================================================
interface miriscv_lsu_if;
  logic        data_req_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic [31:0] data_rdata_i;

  modport master (
    output data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
    input  data_rdata_i
  );

  modport slave (
    input  data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
    output data_rdata_i
  );
endinterface
`default_nettype wire

// File: rtl/miriscv_lsu.sv
`default_nettype none
// ============================================================================
// Module   : miriscv_lsu
// Purpose  : Load/store unit between the execute stage and the RAM data port.
//            Turns funct3-sized byte-addressed accesses into word-aligned RAM
//            requests with byte enables and lane-replicated store data, stalls
//            the core for the registered RAM read, and returns sign/zero
//            extended load data. Every access takes two cycles (request +
//            response); back-to-back accesses are allowed.
// Ports    : clk_i, rst_n_i (async, active-low)
//            lsu_req_i, lsu_we_i, lsu_size_i[2:0], lsu_addr_i[31:0],
//            lsu_data_i[31:0]             core request
//            lsu_data_o[31:0]             extended load data (response cycle)
//            lsu_stall_req_o              hold the core during the request
//            lsu_misalign_o               misaligned access trap
//            data_bus (miriscv_lsu_if.master) RAM data port
// Config   : `define MISALIGN_TRAP_EN to trap misaligned halfword/word
//            accesses instead of silently aligning them.
// Revision : 1.0 - initial release
// ============================================================================
module miriscv_lsu (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 lsu_req_i,
  input  logic                 lsu_we_i,
  input  logic [2:0]           lsu_size_i,
  input  logic [31:0]          lsu_addr_i,
  input  logic [31:0]          lsu_data_i,
  output logic [31:0]          lsu_data_o,
  output logic                 lsu_stall_req_o,
  output logic                 lsu_misalign_o,
  miriscv_lsu_if.master        data_bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t      r_state;
  logic [1:0]  r_offset;
  logic [2:0]  r_size;
  logic        r_we;

  logic        w_idle;
  logic        w_misalign;
  logic        w_start;
  logic        w_resp_load;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;

  assign w_idle = (r_state == IDLE);

`ifdef MISALIGN_TRAP_EN
  // Only real H/HU and W encodings can be misaligned; undefined sizes act as
  // full-word accesses at the aligned address and never trap.
  always_comb begin
    w_misalign = 1'b0;
    case (lsu_size_i)
      3'b001, 3'b101: w_misalign = lsu_addr_i[0];
      3'b010:         w_misalign = (lsu_addr_i[1:0] != 2'b00);
      default:        w_misalign = 1'b0;
    endcase
  end
`else
  assign w_misalign = 1'b0;
`endif

  // rst_n_i is folded into every output so reset silences the bus
  // asynchronously, even in the middle of a request cycle.
  assign w_start         = rst_n_i & w_idle & lsu_req_i & ~w_misalign;
  assign lsu_misalign_o  = rst_n_i & w_idle & lsu_req_i & w_misalign;
  assign lsu_stall_req_o = w_start;

  assign data_bus.data_req_o   = w_start;
  assign data_bus.data_we_o    = w_start & lsu_we_i;
  assign data_bus.data_be_o    = w_be;
  assign data_bus.data_wdata_o = w_wdata;
  assign data_bus.data_addr_o  = rst_n_i ? {lsu_addr_i[31:2], 2'b00} : 32'h0;

  // Byte enables and replicated store data; undefined sizes behave as words.
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = 32'h0;
    if (w_start) begin
      case (lsu_size_i)
        3'b000, 3'b100: begin
          w_be    = 4'b0001 << lsu_addr_i[1:0];
          w_wdata = {4{lsu_data_i[7:0]}};
        end
        3'b001, 3'b101: begin
          w_be    = 4'b0011 << {lsu_addr_i[1], 1'b0};
          w_wdata = {2{lsu_data_i[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = lsu_data_i;
        end
      endcase
    end
  end

  // Lane selection uses the offset captured in the request cycle, because
  // the core may already present the next instruction's address here.
  always_comb begin
    w_byte = 8'h00;
    case (r_offset)
      2'd0:    w_byte = data_bus.data_rdata_i[7:0];
      2'd1:    w_byte = data_bus.data_rdata_i[15:8];
      2'd2:    w_byte = data_bus.data_rdata_i[23:16];
      default: w_byte = data_bus.data_rdata_i[31:24];
    endcase
  end

  assign w_half = r_offset[1] ? data_bus.data_rdata_i[31:16]
                              : data_bus.data_rdata_i[15:0];

  always_comb begin
    w_load = 32'h0;
    case (r_size)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {24'h0, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b101:  w_load = {16'h0, w_half};
      default: w_load = data_bus.data_rdata_i;
    endcase
  end

  assign w_resp_load = rst_n_i & (r_state == RESP) & ~r_we;
  assign lsu_data_o  = w_resp_load ? w_load : 32'h0;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state  <= IDLE;
      r_offset <= 2'b00;
      r_size   <= 3'b000;
      r_we     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state  <= RESP;
            r_offset <= lsu_addr_i[1:0];
            r_size   <= lsu_size_i;
            r_we     <= lsu_we_i;
          end
        end
        default: begin
          // lsu_req_i is ignored here; a new access may start next cycle.
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_miriscv_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_miriscv_lsu
// Purpose  : Self-checking bench for miriscv_lsu with a small registered RAM
//            and a byte-addressed reference memory model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_miriscv_lsu;

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic        lsu_req_i;
  logic        lsu_we_i;
  logic [2:0]  lsu_size_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_data_i;
  logic [31:0] lsu_data_o;
  logic        lsu_stall_req_o;
  logic        lsu_misalign_o;

  miriscv_lsu_if bus ();

  miriscv_lsu dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n_i),
    .lsu_req_i       (lsu_req_i),
    .lsu_we_i        (lsu_we_i),
    .lsu_size_i      (lsu_size_i),
    .lsu_addr_i      (lsu_addr_i),
    .lsu_data_i      (lsu_data_i),
    .lsu_data_o      (lsu_data_o),
    .lsu_stall_req_o (lsu_stall_req_o),
    .lsu_misalign_o  (lsu_misalign_o),
    .data_bus        (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- RAM: 64 words, registered read, byte-enabled write ----
  logic [31:0] init_words [0:63];
  logic [31:0] ram [0:63];
  logic        ram_load;

  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 64; i++) ram[i] <= init_words[i];
    end else if (bus.data_req_o) begin
      for (int l = 0; l < 4; l++)
        if (bus.data_we_o && bus.data_be_o[l])
          ram[bus.data_addr_o[7:2]][8*l +: 8] <= bus.data_wdata_o[8*l +: 8];
      bus.data_rdata_i <= ram[bus.data_addr_o[7:2]];
    end
  end

  // ---------------- Reference model: plain byte memory ---------------------
  logic [7:0] ref_mem [0:255];

  function automatic int unsigned size_bytes(input logic [2:0] s);
    if (s == 3'b000 || s == 3'b100) return 1;
    if (s == 3'b001 || s == 3'b101) return 2;
    return 4;
  endfunction

  function automatic bit misaligned(input logic [2:0] s, input logic [7:0] a);
    if (!TRAP_EN) return 1'b0;
    if (s == 3'b001 || s == 3'b101) return (a % 2) != 0;
    if (s == 3'b010) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] s, input logic [7:0] a);
    int unsigned n;
    int unsigned base;
    longint      v;
    n    = size_bytes(s);
    base = a - (a % n);
    v    = 0;
    for (int i = 0; i < n; i++) v += longint'(ref_mem[base + i]) << (8 * i);
    if ((s == 3'b000 || s == 3'b001) && v >= (longint'(1) << (8 * n - 1)))
      v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  // One complete access; compares request-cycle and response-cycle outputs.
  task automatic do_access(input logic we, input logic [2:0] s, input logic [31:0] a,
                           input logic [31:0] d, input bit junk, output logic [31:0] rd);
    int unsigned n;
    int unsigned base;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    logic [31:0] exp_ld;
    bit          trap;
    n      = size_bytes(s);
    base   = a[7:0] - (a[7:0] % n);
    trap   = misaligned(s, a[7:0]);
    exp_be = 4'b0000;
    for (int i = 0; i < n; i++) exp_be[(base + i) % 4] = 1'b1;
    for (int k = 0; k < 4; k++) exp_wd[8*k +: 8] = d[8*(k % n) +: 8];
    exp_ld = we ? 32'h0 : ref_load(s, a[7:0]);
    rd     = 32'h0;

    @(negedge clk);
    lsu_req_i = 1'b1; lsu_we_i = we; lsu_size_i = s; lsu_addr_i = a; lsu_data_i = d;
    #1;
    if (trap) begin
      checks++;
      if ({lsu_misalign_o, bus.data_req_o, lsu_stall_req_o, bus.data_we_o, bus.data_be_o, bus.data_wdata_o}
          !== {1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0}) begin
        errors++;
        $display("FAIL trap_cycle: got mis=%b req=%b stall=%b we=%b be=%b wd=%h, expected mis=1 req=0 stall=0 we=0 be=0000 wd=0",
                 lsu_misalign_o, bus.data_req_o, lsu_stall_req_o, bus.data_we_o, bus.data_be_o, bus.data_wdata_o);
      end
      lsu_req_i = 1'b0;
      @(negedge clk); #1;
      checks++;
      if ({bus.data_req_o, lsu_stall_req_o, lsu_data_o} !== {1'b0, 1'b0, 32'h0}) begin
        errors++;
        $display("FAIL trap_stays_idle: got req=%b stall=%b data=%h, expected 0 0 0",
                 bus.data_req_o, lsu_stall_req_o, lsu_data_o);
      end
    end else begin
      checks++;
      if ({bus.data_req_o, lsu_stall_req_o, lsu_misalign_o, bus.data_we_o, bus.data_be_o}
          !== {1'b1, 1'b1, 1'b0, we, exp_be}) begin
        errors++;
        $display("FAIL req_cycle (s=%b a=%h): got req=%b stall=%b mis=%b we=%b be=%b, expected 1 1 0 %b %b",
                 s, a, bus.data_req_o, lsu_stall_req_o, lsu_misalign_o, bus.data_we_o, bus.data_be_o, we, exp_be);
      end
      checks++;
      if ({bus.data_addr_o, bus.data_wdata_o} !== {a & 32'hFFFF_FFFC, exp_wd}) begin
        errors++;
        $display("FAIL req_addr_wdata (s=%b a=%h): got addr=%h wd=%h, expected addr=%h wd=%h",
                 s, a, bus.data_addr_o, bus.data_wdata_o, a & 32'hFFFF_FFFC, exp_wd);
      end
      @(negedge clk);
      if (junk) begin
        lsu_req_i = 1'b1; lsu_we_i = $urandom_range(0, 1); lsu_size_i = 3'($urandom_range(0, 7));
        lsu_addr_i = $urandom; lsu_data_i = $urandom;
      end else begin
        lsu_req_i = 1'b0;
      end
      #1;
      checks++;
      if ({bus.data_req_o, lsu_stall_req_o, lsu_misalign_o, bus.data_we_o, bus.data_be_o, bus.data_wdata_o}
          !== {1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0}) begin
        errors++;
        $display("FAIL resp_cycle_ctrl: got req=%b stall=%b mis=%b we=%b be=%b wd=%h, expected all 0",
                 bus.data_req_o, lsu_stall_req_o, lsu_misalign_o, bus.data_we_o, bus.data_be_o, bus.data_wdata_o);
      end
      checks++;
      if (lsu_data_o !== exp_ld) begin
        errors++;
        $display("FAIL resp_data (we=%b s=%b a=%h): got %h expected %h", we, s, a, lsu_data_o, exp_ld);
      end
      rd = lsu_data_o;
      if (we) for (int i = 0; i < n; i++) ref_mem[base + i] = d[8*i +: 8];
      lsu_req_i = 1'b0;
    end
  endtask

  // ---------------- Tests --------------------------------------------------
  task automatic test_reset();
    rst_n_i = 1'b0; ram_load = 1'b1;
    lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_size_i = 3'b010;
    lsu_addr_i = 32'hDEAD_BE13; lsu_data_i = 32'hFFFF_FFFF;
    #1;
    checks++;
    if ({lsu_data_o, lsu_stall_req_o, lsu_misalign_o, bus.data_req_o, bus.data_we_o,
         bus.data_be_o, bus.data_addr_o, bus.data_wdata_o} !== 104'h0) begin
      errors++;
      $display("FAIL reset_outputs: got data=%h stall=%b mis=%b req=%b we=%b be=%b addr=%h wd=%h, expected all 0",
               lsu_data_o, lsu_stall_req_o, lsu_misalign_o, bus.data_req_o, bus.data_we_o,
               bus.data_be_o, bus.data_addr_o, bus.data_wdata_o);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    ram_load = 1'b0; lsu_req_i = 1'b0; rst_n_i = 1'b1;
    #1;
    checks++;
    if ({bus.data_req_o, lsu_stall_req_o, lsu_data_o} !== {1'b0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset_release_idle: got req=%b stall=%b data=%h, expected 0 0 0",
               bus.data_req_o, lsu_stall_req_o, lsu_data_o);
    end
  endtask

  task automatic test_loads();
    logic [31:0] rd;
    logic [2:0]  sz   [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [31:0] ad   [5] = '{32'h13, 32'h12, 32'h10, 32'h12, 32'h10};
    logic [31:0] want [5] = '{32'hFFFF_FF88, 32'h0000_0099, 32'hFFFF_AABB, 32'h0000_8899, 32'h8899_AABB};
    for (int i = 0; i < 5; i++) begin
      do_access(1'b0, sz[i], ad[i], 32'h0, 1'b0, rd);
      checks++;
      if (rd !== want[i]) begin
        errors++;
        $display("FAIL load_directed[%0d]: got %h expected %h", i, rd, want[i]);
      end
    end
  endtask

  task automatic test_misalign();
    logic [31:0] rd;
    logic [31:0] want;
    want = TRAP_EN ? 32'h0 : 32'h8899_AABB;
    do_access(1'b0, 3'b010, 32'h11, 32'h0, 1'b0, rd);
    checks++;
    if (rd !== want) begin
      errors++;
      $display("FAIL misalign_lw: got %h expected %h", rd, want);
    end
  endtask

  task automatic test_stores();
    logic [31:0] rd;
    do_access(1'b1, 3'b000, 32'h11, 32'h0000_005A, 1'b0, rd);
    checks++;
    if (ram[4] !== 32'h8899_5ABB) begin
      errors++;
      $display("FAIL sb_ram_word: got %h expected %h", ram[4], 32'h8899_5ABB);
    end
    do_access(1'b1, 3'b001, 32'h12, 32'h0000_1234, 1'b0, rd);
    do_access(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, rd);
    checks++;
    if (rd !== 32'h1234_5ABB) begin
      errors++;
      $display("FAIL store_readback: got %h expected %h", rd, 32'h1234_5ABB);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [31:0] exp_lw;
    d      = $urandom;
    exp_lw = ref_load(3'b010, 8'h10);
    @(negedge clk);
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 3'b010; lsu_addr_i = 32'h10; lsu_data_i = 32'h0;
    #1;
    checks++;
    if ({bus.data_req_o, lsu_stall_req_o} !== 2'b11) begin
      errors++;
      $display("FAIL b2b_cycle0: got req/stall=%b expected 11", {bus.data_req_o, lsu_stall_req_o});
    end
    @(negedge clk);
    lsu_we_i = 1'b1; lsu_addr_i = 32'h14; lsu_data_i = d;
    #1;
    checks++;
    if ({bus.data_req_o, lsu_stall_req_o, lsu_data_o} !== {2'b00, exp_lw}) begin
      errors++;
      $display("FAIL b2b_cycle1: got req/stall=%b data=%h expected 00 %h",
               {bus.data_req_o, lsu_stall_req_o}, lsu_data_o, exp_lw);
    end
    @(negedge clk); #1;
    checks++;
    if ({bus.data_req_o, lsu_stall_req_o, bus.data_we_o, bus.data_be_o, bus.data_wdata_o}
        !== {3'b111, 4'b1111, d}) begin
      errors++;
      $display("FAIL b2b_cycle2: got req/stall/we=%b be=%b wd=%h expected 111 1111 %h",
               {bus.data_req_o, lsu_stall_req_o, bus.data_we_o}, bus.data_be_o, bus.data_wdata_o, d);
    end
    @(negedge clk); #1;
    checks++;
    if ({bus.data_req_o, lsu_stall_req_o, lsu_data_o} !== {2'b00, 32'h0}) begin
      errors++;
      $display("FAIL b2b_cycle3: got req/stall=%b data=%h expected 00 0",
               {bus.data_req_o, lsu_stall_req_o}, lsu_data_o);
    end
    lsu_req_i = 1'b0;
    for (int i = 0; i < 4; i++) ref_mem[8'h14 + i] = d[8*i +: 8];
    @(negedge clk);
    checks++;
    if (ram[5] !== d) begin
      errors++;
      $display("FAIL b2b_ram_word: got %h expected %h", ram[5], d);
    end
  endtask

  task automatic test_reset_mid_resp();
    logic [31:0] rd;
    @(negedge clk);
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 3'b010; lsu_addr_i = 32'h10;
    @(negedge clk);
    #1;
    rst_n_i = 1'b0;
    #1;
    checks++;
    if ({lsu_data_o, lsu_stall_req_o, lsu_misalign_o, bus.data_req_o, bus.data_we_o,
         bus.data_be_o, bus.data_addr_o, bus.data_wdata_o} !== 104'h0) begin
      errors++;
      $display("FAIL reset_mid_resp: got data=%h stall=%b mis=%b req=%b we=%b be=%b addr=%h wd=%h, expected all 0",
               lsu_data_o, lsu_stall_req_o, lsu_misalign_o, bus.data_req_o, bus.data_we_o,
               bus.data_be_o, bus.data_addr_o, bus.data_wdata_o);
    end
    @(negedge clk);
    lsu_req_i = 1'b0; rst_n_i = 1'b1;
    #1;
    checks++;
    if ({bus.data_req_o, lsu_stall_req_o, lsu_data_o} !== {2'b00, 32'h0}) begin
      errors++;
      $display("FAIL reset_mid_release: got req/stall=%b data=%h expected 00 0",
               {bus.data_req_o, lsu_stall_req_o}, lsu_data_o);
    end
    do_access(1'b0, 3'b100, 32'h10, 32'h0, 1'b0, rd);
    checks++;
    if (rd !== 32'h0000_00BB) begin
      errors++;
      $display("FAIL lbu_after_reset: got %h expected %h", rd, 32'h0000_00BB);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd;
    for (int t = 0; t < 300; t++) begin
      do_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                {24'($urandom), 8'($urandom)}, $urandom, 1'($urandom_range(0, 1)), rd);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk); #1;
        checks++;
        if ({bus.data_req_o, lsu_stall_req_o, lsu_data_o} !== {2'b00, 32'h0}) begin
          errors++;
          $display("FAIL random_idle: got req/stall=%b data=%h expected 00 0",
                   {bus.data_req_o, lsu_stall_req_o}, lsu_data_o);
        end
      end
    end
  endtask

  initial begin
    for (int w = 0; w < 64; w++) init_words[w] = $urandom;
    init_words[4] = 32'h8899_AABB;
    for (int w = 0; w < 64; w++)
      for (int b = 0; b < 4; b++) ref_mem[4*w + b] = init_words[w][8*b +: 8];

    test_reset();
    test_loads();
    test_misalign();
    test_stores();
    test_back_to_back();
    test_reset_mid_resp();
    test_random();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
